mac_sequencer: RTL

MAC_SEQUENCER -- requirements
Module: mac_sequencer

---
 rtl/mac_pkg.sv | 58 +++++
 rtl/acc_requant.sv | 22 ++
 rtl/mac_sequencer.sv | 108 ++++++++++
 3 files changed

// File: rtl/mac_pkg.sv
// Shared number formats, sequencer state type and the round/saturate helper.
// Build option: define MAC_SEQ_RELU_EN to clamp negative neuron outputs to zero.
package mac_pkg;

  localparam int unsigned DEF_BITS_INT = 4;
  localparam int unsigned DEF_BITS_FRC = 12;
  localparam int unsigned DEF_WGHT_INT = 6;
  localparam int unsigned DEF_WGHT_FRC = 10;
  localparam int unsigned DEF_WIDTH    = 784;

  // Working width for requantization; comfortably wider than AW+1.
  localparam int unsigned CALC_W = 64;

`ifdef MAC_SEQ_RELU_EN
  localparam bit RELU_EN_DEF = 1'b1;
`else
  localparam bit RELU_EN_DEF = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    RUN,
    WAIT,
    CAPTURE,
    OUT
  } state_e;

  // Round half up, drop frc fraction bits, saturate to a signed pw-bit range.
  function automatic logic signed [CALC_W-1:0] round_sat(
    input logic signed [CALC_W-1:0] acc,
    input int unsigned              frc,
    input int unsigned              pw,
    input bit                       relu
  );
    logic signed [CALC_W-1:0] half;
    logic signed [CALC_W-1:0] shr;
    logic signed [CALC_W-1:0] max_v;
    logic signed [CALC_W-1:0] min_v;
    logic signed [CALC_W-1:0] res;
    half  = (frc == 0) ? 64'sd0 : (64'sd1 <<< (frc - 1));
    shr   = (acc + half) >>> frc;
    max_v = (64'sd1 <<< (pw - 1)) - 64'sd1;
    min_v = -(64'sd1 <<< (pw - 1));
    if (shr > max_v) begin
      res = max_v;
    end else if (shr < min_v) begin
      res = min_v;
    end else begin
      res = shr;
    end
    if (relu && (res < 64'sd0)) begin
      res = 64'sd0;
    end
    return res;
  endfunction

endpackage

// File: rtl/acc_requant.sv
// Combinational requantization of the MAC accumulator to the pixel format.
// ReLU clamping follows MAC_SEQ_RELU_EN through the RELU_EN default.
module acc_requant
  import mac_pkg::*;
#(
  parameter int unsigned AW      = 32,
  parameter int unsigned FRC     = 10,
  parameter int unsigned PW      = 16,
  parameter bit          RELU_EN = RELU_EN_DEF
) (
  input  logic [AW-1:0] acc_i,
  output logic [PW-1:0] result_o
);

  logic signed [CALC_W-1:0] acc_ext;

  always_comb begin
    acc_ext  = {{(CALC_W - AW){acc_i[AW-1]}}, acc_i};
    result_o = PW'(round_sat(acc_ext, FRC, PW, RELU_EN));
  end

endmodule

// File: rtl/mac_sequencer.sv
// Sequences one neuron evaluation: clears the MAC, streams WIDTH pixel/weight
// pairs, requantizes the accumulator and hands the result off with valid/ready.
// Build option: MAC_SEQ_RELU_EN (see mac_pkg).
module mac_sequencer
  import mac_pkg::*;
#(
  parameter int unsigned BITS_INT = DEF_BITS_INT,
  parameter int unsigned BITS_FRC = DEF_BITS_FRC,
  parameter int unsigned WGHT_INT = DEF_WGHT_INT,
  parameter int unsigned WGHT_FRC = DEF_WGHT_FRC,
  parameter int unsigned WIDTH    = DEF_WIDTH,
  localparam int unsigned PW      = BITS_INT + BITS_FRC,
  localparam int unsigned WW      = WGHT_INT + WGHT_FRC,
  localparam int unsigned AW      = PW + WW,
  localparam int unsigned ADDR_W  = $clog2(WIDTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_i,
  output logic              busy_o,
  output logic [ADDR_W-1:0] addr_o,
  input  logic [PW-1:0]     pix_data_i,
  input  logic [WW-1:0]     wght_data_i,
  output logic [PW-1:0]     picture_o,
  output logic [WW-1:0]     weight_o,
  output logic              mac_clr_n_o,
  input  logic [AW-1:0]     acc_i,
  output logic [PW-1:0]     result_o,
  output logic              valid_o,
  input  logic              ready_i
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              feed_q, feed_d;
  logic [PW-1:0]     result_q, result_d;
  logic              valid_q, valid_d;
  logic [PW-1:0]     requant;

  acc_requant #(
    .AW (AW),
    .FRC(WGHT_FRC),
    .PW (PW)
  ) u_requant (
    .acc_i   (acc_i),
    .result_o(requant)
  );

  // valid_o is registered from OUT, so it rises one cycle after OUT is entered.
  always_comb begin
    state_d  = state_q;
    addr_d   = '0;
    feed_d   = (state_q == RUN);
    result_d = result_q;
    valid_d  = 1'b0;
    case (state_q)
      IDLE:    if (start_i) state_d = CLEAR;
      CLEAR:   state_d = RUN;
      RUN: begin
        if (addr_q == LAST_ADDR) begin
          state_d = WAIT;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      WAIT:    state_d = CAPTURE;
      CAPTURE: begin
        result_d = requant;
        state_d  = OUT;
      end
      OUT: begin
        if (valid_q && ready_i) begin
          state_d = IDLE;
        end else begin
          valid_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      feed_q   <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      feed_q   <= feed_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign mac_clr_n_o = !((state_q == IDLE) || (state_q == CLEAR));
  assign addr_o      = addr_q;
  assign picture_o   = feed_q ? pix_data_i : '0;
  assign weight_o    = feed_q ? wght_data_i : '0;
  assign result_o    = result_q;
  assign valid_o     = valid_q;

endmodule
